// File: rtl/dcache_pkg.sv
// Shared types and default address-field geometry for the data cache.
package dcache_pkg;

   localparam int unsigned ADDR_W          = 8;
   localparam int unsigned DEF_NUM_LINES   = 8;
   localparam int unsigned DEF_BLOCK_BYTES = 4;

   localparam int unsigned OFFSET_W = $clog2(DEF_BLOCK_BYTES);
   localparam int unsigned INDEX_W  = $clog2(DEF_NUM_LINES);
   localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      FETCH,
      UPDATE
   } state_t;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
      return a[OFFSET_W +: INDEX_W];
   endfunction

   function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
      return a[OFFSET_W-1:0];
   endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Line storage for the data cache: valid/dirty flags, tags and data bytes.
// One shared index port serves the combinational read, the byte write and
// the full-line install.
module dcache_line_store
   import dcache_pkg::*;
#(
   parameter int unsigned NUM_LINES   = 8,
   parameter int unsigned BLOCK_BYTES = 4,
   parameter int unsigned TAG_BITS    = 3,
   parameter int unsigned INDEX_BITS  = 3,
   parameter int unsigned OFFSET_BITS = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [INDEX_BITS-1:0]    index,
   output logic                     valid,
   output logic                     dirty,
   output logic [TAG_BITS-1:0]      tag,
   output logic [BLOCK_BYTES*8-1:0] data,
   input  logic                     byte_we,
   input  logic [OFFSET_BITS-1:0]   byte_offset,
   input  logic [7:0]               byte_data,
   input  logic                     line_we,
   input  logic [TAG_BITS-1:0]      line_tag,
   input  logic [BLOCK_BYTES*8-1:0] line_data
);

   logic [NUM_LINES-1:0]     valid_bits;
   logic [NUM_LINES-1:0]     dirty_bits;
   logic [TAG_BITS-1:0]      tag_mem  [NUM_LINES];
   logic [BLOCK_BYTES*8-1:0] data_mem [NUM_LINES];

   // Flags: cleared asynchronously, install sets valid/clean, byte write marks dirty
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_bits <= '0;
         dirty_bits <= '0;
      end else if (line_we) begin
         valid_bits[index] <= 1'b1;
         dirty_bits[index] <= 1'b0;
      end else if (byte_we) begin
         dirty_bits[index] <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset; they are qualified by the valid flag
   always_ff @(posedge clock) begin
      if (line_we) begin
         tag_mem[index]  <= line_tag;
         data_mem[index] <= line_data;
      end else if (byte_we) begin
         data_mem[index][{byte_offset, 3'b000} +: 8] <= byte_data;
      end
   end

   // Combinational read of the indexed line
   always_comb begin
      valid = valid_bits[index];
      dirty = dirty_bits[index];
      tag   = tag_mem[index];
      data  = data_mem[index];
   end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Hits complete with zero wait; misses write back a dirty victim and then
// fetch the block one byte at a time over the memory strobe handshake.
// Optional build macro DCACHE_STATS_EN adds saturating hit/miss counters.
module dcache_controller
   import dcache_pkg::*;
#(
   parameter int unsigned NUM_LINES   = 8,
   parameter int unsigned BLOCK_BYTES = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [7:0]  cpu_address,
   input  logic [7:0]  cpu_writedata,
   output logic [7:0]  cpu_readdata,
   output logic        cpu_busywait,
   output logic        mem_read,
   output logic        mem_write,
   output logic [7:0]  mem_address,
   output logic [7:0]  mem_writedata,
   input  logic [7:0]  mem_readdata,
   input  logic        mem_busywait,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
);

   localparam int unsigned LINE_OFFSET_W = $clog2(BLOCK_BYTES);
   localparam int unsigned LINE_INDEX_W  = $clog2(NUM_LINES);
   localparam int unsigned LINE_TAG_W    = 8 - LINE_INDEX_W - LINE_OFFSET_W;
   localparam int unsigned LINE_W        = BLOCK_BYTES * 8;
   localparam logic [LINE_OFFSET_W-1:0] LAST_BYTE = LINE_OFFSET_W'(BLOCK_BYTES - 1);

   state_t                   state;
   logic [LINE_OFFSET_W-1:0] byte_cnt;
   logic [LINE_TAG_W-1:0]    miss_tag;
   logic [LINE_INDEX_W-1:0]  miss_index;
   logic [LINE_W-1:0]        fill_buf;

   logic [LINE_TAG_W-1:0]    cpu_tag;
   logic [LINE_INDEX_W-1:0]  cpu_index;
   logic [LINE_OFFSET_W-1:0] cpu_offset;
   logic [LINE_INDEX_W-1:0]  store_index;

   logic                     line_valid;
   logic                     line_dirty;
   logic [LINE_TAG_W-1:0]    line_tag;
   logic [LINE_W-1:0]        line_data;

   logic                     request;
   logic                     hit;
   logic                     write_hit;
   logic                     install;

   assign cpu_tag    = cpu_address[7 -: LINE_TAG_W];
   assign cpu_index  = cpu_address[LINE_OFFSET_W +: LINE_INDEX_W];
   assign cpu_offset = cpu_address[LINE_OFFSET_W-1:0];

   // Line lookup, hit detection and CPU-side outputs
   always_comb begin
      store_index  = (state == IDLE) ? cpu_index : miss_index;
      request      = cpu_read | cpu_write;
      hit          = line_valid && (line_tag == cpu_tag);
      write_hit    = (state == IDLE) && cpu_write && hit;
      install      = (state == UPDATE);
      cpu_busywait = (state != IDLE) || (request && !hit);
      cpu_readdata = '0;
      if ((state == IDLE) && cpu_read && !cpu_write && hit)
         cpu_readdata = line_data[{cpu_offset, 3'b000} +: 8];
   end

   dcache_line_store #(
      .NUM_LINES   (NUM_LINES),
      .BLOCK_BYTES (BLOCK_BYTES),
      .TAG_BITS    (LINE_TAG_W),
      .INDEX_BITS  (LINE_INDEX_W),
      .OFFSET_BITS (LINE_OFFSET_W)
   ) u_store (
      .clock       (clock),
      .reset       (reset),
      .index       (store_index),
      .valid       (line_valid),
      .dirty       (line_dirty),
      .tag         (line_tag),
      .data        (line_data),
      .byte_we     (write_hit),
      .byte_offset (cpu_offset),
      .byte_data   (cpu_writedata),
      .line_we     (install),
      .line_tag    (miss_tag),
      .line_data   (fill_buf)
   );

   // Miss sequencer; a low strobe inside WRITEBACK/FETCH marks the one-cycle gap
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         byte_cnt      <= '0;
         mem_read      <= 1'b0;
         mem_write     <= 1'b0;
         mem_address   <= '0;
         mem_writedata <= '0;
         miss_tag      <= '0;
         miss_index    <= '0;
         fill_buf      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (request && !hit) begin
                  miss_tag   <= cpu_tag;
                  miss_index <= cpu_index;
                  byte_cnt   <= '0;
                  if (line_valid && line_dirty) begin
                     state         <= WRITEBACK;
                     mem_write     <= 1'b1;
                     mem_address   <= {line_tag, cpu_index, {LINE_OFFSET_W{1'b0}}};
                     mem_writedata <= line_data[7:0];
                  end else begin
                     state       <= FETCH;
                     mem_read    <= 1'b1;
                     mem_address <= {cpu_tag, cpu_index, {LINE_OFFSET_W{1'b0}}};
                  end
               end
            end
            WRITEBACK: begin
               if (!mem_write) begin
                  mem_write     <= 1'b1;
                  mem_address   <= {line_tag, miss_index, byte_cnt};
                  mem_writedata <= line_data[{byte_cnt, 3'b000} +: 8];
               end else if (!mem_busywait) begin
                  mem_write <= 1'b0;
                  if (byte_cnt == LAST_BYTE) begin
                     byte_cnt <= '0;
                     state    <= FETCH;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            FETCH: begin
               if (!mem_read) begin
                  mem_read    <= 1'b1;
                  mem_address <= {miss_tag, miss_index, byte_cnt};
               end else if (!mem_busywait) begin
                  mem_read <= 1'b0;
                  fill_buf[{byte_cnt, 3'b000} +: 8] <= mem_readdata;
                  if (byte_cnt == LAST_BYTE) begin
                     byte_cnt <= '0;
                     state    <= UPDATE;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            UPDATE: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   // Saturating hit/miss counters
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state == IDLE && request) begin
         if (hit && hit_count != 16'hFFFF)
            hit_count <= hit_count + 16'd1;
         if (!hit && miss_count != 16'hFFFF)
            miss_count <= miss_count + 16'd1;
      end
   end
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: a latency-programmable byte
// memory, a reference cache/memory model and a read-data scoreboard.
module tb_dcache_controller;
   import dcache_pkg::*;

   localparam int unsigned BB = DEF_BLOCK_BYTES;
`ifdef DCACHE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        cpu_read, cpu_write;
   logic [7:0]  cpu_address, cpu_writedata, cpu_readdata;
   logic        cpu_busywait;
   logic        mem_read, mem_write;
   logic [7:0]  mem_address, mem_writedata, mem_readdata;
   logic        mem_busywait;
   logic [15:0] hit_count, miss_count;

   dcache_controller #(
      .NUM_LINES   (DEF_NUM_LINES),
      .BLOCK_BYTES (DEF_BLOCK_BYTES)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .cpu_read      (cpu_read),
      .cpu_write     (cpu_write),
      .cpu_address   (cpu_address),
      .cpu_writedata (cpu_writedata),
      .cpu_readdata  (cpu_readdata),
      .cpu_busywait  (cpu_busywait),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_address   (mem_address),
      .mem_writedata (mem_writedata),
      .mem_readdata  (mem_readdata),
      .mem_busywait  (mem_busywait),
      .hit_count     (hit_count),
      .miss_count    (miss_count)
   );

   always #5 clock = ~clock;

   // Memory model and strobe log
   logic [7:0]  mem [256];
   int          lat = 2;
   int          lat_cnt = 0;
   int          cyc = 0;
   logic        prev_read = 1'b0;
   logic [7:0]  rd_addr_q[$];
   int          rd_cyc_q[$];
   logic [15:0] wr_q[$];
   int          wr_cyc_q[$];

   assign mem_readdata = mem[mem_address];
   assign mem_busywait = (mem_read || mem_write) && (lat_cnt < lat - 1);

   // Memory timing, writes and strobe logging
   always @(posedge clock) begin
      cyc       <= cyc + 1;
      prev_read <= mem_read;
      lat_cnt   <= (mem_read || mem_write) ? lat_cnt + 1 : 0;
      if (mem_read && !prev_read) begin
         rd_addr_q.push_back(mem_address);
         rd_cyc_q.push_back(cyc);
      end
      if (mem_write && !mem_busywait) begin
         mem[mem_address] <= mem_writedata;
         wr_q.push_back({mem_address, mem_writedata});
         wr_cyc_q.push_back(cyc);
      end
   end

   // Reference model
   logic [7:0]       ref_mem [256];
   logic [TAG_W-1:0] m_tag   [DEF_NUM_LINES];
   bit               m_valid [DEF_NUM_LINES];
   bit               m_dirty [DEF_NUM_LINES];
   logic [15:0]      exp_hits, exp_misses;
   logic [7:0]       exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEF_NUM_LINES; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_tag[i]   = '0;
      end
      for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
      exp_hits   = '0;
      exp_misses = '0;
   endtask

   task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                         input logic [7:0] wdata);
      logic [TAG_W-1:0]   tg;
      logic [INDEX_W-1:0] idx;
      logic [7:0]         vaddr, exp_rd;
      bit                 hit, dirty, done;
      int                 waits, exp_waits;
      tg        = addr_tag(addr);
      idx       = addr_index(addr);
      hit       = m_valid[idx] && (m_tag[idx] == tg);
      dirty     = !hit && m_valid[idx] && m_dirty[idx];
      exp_waits = hit ? 0 : (dirty ? 2 * BB : BB) * (lat + 1) + 1;
      @(posedge clock); #1;
      rd_addr_q.delete(); rd_cyc_q.delete(); wr_q.delete(); wr_cyc_q.delete();
      cpu_read      = rd;
      cpu_write     = wr;
      cpu_address   = addr;
      cpu_writedata = wdata;
      if (!wr) exp_q.push_back(ref_mem[addr]);
      waits = 0;
      done  = 1'b0;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clock);
         if (!cpu_busywait) done = 1'b1;
         else waits++;
      end
      check("complete", done, 1);
      check("wait_cycles", waits, exp_waits);
      if (!wr && exp_q.size() > 0) begin
         exp_rd = exp_q.pop_front();
         check("readdata", cpu_readdata, exp_rd);
      end
      @(posedge clock); #1;
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
      check("read_strobes", rd_addr_q.size(), hit ? 0 : BB);
      check("write_strobes", wr_q.size(), dirty ? BB : 0);
      for (int i = 0; i < wr_q.size(); i++) begin
         vaddr = {m_tag[idx], idx, OFFSET_W'(i)};
         check("wb_addr", wr_q[i][15:8], vaddr);
         check("wb_data", wr_q[i][7:0], ref_mem[vaddr]);
         if (i > 0) check("wb_period", wr_cyc_q[i] - wr_cyc_q[i-1], lat + 1);
      end
      for (int i = 0; i < rd_addr_q.size(); i++) begin
         vaddr = {addr[7:OFFSET_W], OFFSET_W'(i)};
         check("fetch_addr", rd_addr_q[i], vaddr);
         if (i > 0) check("fetch_period", rd_cyc_q[i] - rd_cyc_q[i-1], lat + 1);
      end
      if (!hit) begin
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tg;
         m_dirty[idx] = 1'b0;
         exp_misses   = exp_misses + 16'd1;
      end
      exp_hits = exp_hits + 16'd1;
      if (wr) begin
         m_dirty[idx]  = 1'b1;
         ref_mem[addr] = wdata;
      end
      check("hit_count", hit_count, STATS ? exp_hits : 16'd0);
      check("miss_count", miss_count, STATS ? exp_misses : 16'd0);
   endtask

   initial begin
      int op;
      for (int i = 0; i < 256; i++) mem[i] = 8'((i * 37 + 11) & 8'hFF);
      cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = '0; cpu_writedata = '0;
      reset = 1'b1;
      #1;
      check("rst_mem_read", mem_read, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_mem_address", mem_address, 0);
      check("rst_mem_writedata", mem_writedata, 0);
      check("rst_cpu_readdata", cpu_readdata, 0);
      check("rst_cpu_busywait", cpu_busywait, 0);
      check("rst_hit_count", hit_count, 0);
      check("rst_miss_count", miss_count, 0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      model_reset();

      // Clean miss, hit, write hit, then dirty eviction
      lat = 2;
      access(1'b1, 1'b0, 8'h05, 8'h00);
      access(1'b1, 1'b0, 8'h06, 8'h00);
      access(1'b0, 1'b1, 8'h05, 8'hAB);
      access(1'b1, 1'b0, 8'h25, 8'h00);
      check("wb_mem_05", mem[8'h05], 8'hAB);

      // Read and write together act as a write
      access(1'b1, 1'b1, 8'h10, 8'h3C);
      access(1'b1, 1'b0, 8'h10, 8'h00);

      // Latency extremes
      lat = 1;
      access(1'b1, 1'b0, 8'h80, 8'h00);
      lat = 5;
      access(1'b1, 1'b0, 8'hC4, 8'h00);
      access(1'b0, 1'b1, 8'hC4, 8'h5E);
      access(1'b1, 1'b0, 8'h44, 8'h00);

      // Reset during the third fetch byte
      lat = 3;
      @(posedge clock); #1;
      rd_addr_q.delete(); rd_cyc_q.delete();
      cpu_read    = 1'b1;
      cpu_address = 8'h0B;
      for (int n = 0; n < 100 && rd_addr_q.size() < 3; n++) @(posedge clock);
      check("third_fetch_seen", rd_addr_q.size(), 3);
      #2;
      check("strobe_before_reset", mem_read, 1);
      reset = 1'b1;
      #1;
      check("reset_drops_read", mem_read, 0);
      check("reset_drops_write", mem_write, 0);
      cpu_read = 1'b0;
      #1;
      check("reset_idle_busy", cpu_busywait, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      model_reset();
      check("reset_hits_clear", hit_count, 0);
      check("reset_miss_clear", miss_count, 0);
      access(1'b1, 1'b0, 8'h0B, 8'h00);

      // Mixed traffic over a small address window
      for (int k = 0; k < 24; k++) begin
         lat = $urandom_range(1, 4);
         op  = $urandom_range(0, 2);
         access(op != 1, op >= 1, 8'($urandom_range(0, 63)), 8'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
